// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: ordered-set width, one-hot speed bit positions,
// per-speed emission intervals and the pacer state encoding.
package ltssm_pkg;

   localparam int TS_W = 128;

   localparam int SPD_GEN1 = 0;
   localparam int SPD_GEN2 = 1;
   localparam int SPD_GEN3 = 2;
   localparam int SPD_GEN4 = 3;
   localparam int SPD_GEN5 = 4;

   localparam int GAP_GEN1 = 64;
   localparam int GAP_GEN2 = 32;
   localparam int GAP_GEN3 = 16;
   localparam int GAP_GEN4 = 8;
   localparam int GAP_GEN5 = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_WAIT = 2'd2
   } pacer_state_t;

   // Lowest set speed bit wins; no valid speed bit falls back to the Gen1 interval.
   function automatic logic [6:0] speed2gap(logic [5:0] speed);
      logic [6:0] gap;
      if (speed[SPD_GEN1])      gap = 7'(GAP_GEN1);
      else if (speed[SPD_GEN2]) gap = 7'(GAP_GEN2);
      else if (speed[SPD_GEN3]) gap = 7'(GAP_GEN3);
      else if (speed[SPD_GEN4]) gap = 7'(GAP_GEN4);
      else if (speed[SPD_GEN5]) gap = 7'(GAP_GEN5);
      else                      gap = 7'(GAP_GEN1);
      return gap;
   endfunction

endpackage

// File: rtl/ts_fifo.sv
// Synchronous ordered-set FIFO with occupancy-based full/empty, flush, and
// write-through to the read port when empty so an idle pacer emits next cycle.
module ts_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 128
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [W-1:0]           wr_data,
   input  logic                   rd_en,
   input  logic                   flush,
   output logic [W-1:0]           rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign push    = wr_en && !full && !flush;
   assign pop     = rd_en && !flush && (!empty || push);
   assign rd_data = empty ? wr_data : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         // Realign the read pointer so the emptied FIFO starts clean.
         rd_ptr <= wr_ptr;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      cnt <= cnt + CW'(1);
         else if (pop && !push) cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/lane_tx_pacer.sv
// Per-lane transmit pacer: queues ordered sets and releases one per speed
// interval, modelling serial-line throughput between two simulated LTSSMs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | nothing emitted last cycle, gap is 0; emits as soon as data
// ST_EMIT | a TS was popped last cycle; ts_out_vld is high
// ST_WAIT | gap != 0, counting down the current interval
module lane_tx_pacer #(
   parameter int DEPTH = 4,
   parameter int TS_W  = ltssm_pkg::TS_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [TS_W-1:0]        ts_in,
   input  logic                   ts_in_vld,
   output logic                   fifo_full,
   input  logic [5:0]             curr_speed,
   input  logic                   flush,
   output logic [TS_W-1:0]        ts_out,
   output logic                   ts_out_vld,
   output logic                   ovf_err,
   output logic [$clog2(DEPTH):0] fifo_cnt
);
   import ltssm_pkg::*;

   pacer_state_t    state_q;
   pacer_state_t    state_d;
   logic [5:0]      gap_q;
   logic [5:0]      gap_d;
   logic            emit;
   logic            fifo_empty;
   logic [TS_W-1:0] head;

   ts_fifo #(.DEPTH(DEPTH), .W(TS_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (ts_in_vld),
      .wr_data (ts_in),
      .rd_en   (emit),
      .flush   (flush),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .cnt     (fifo_cnt)
   );

   always_comb begin
      state_d = ST_IDLE;
      gap_d   = gap_q;
      emit    = 1'b0;
      if (flush) begin
         gap_d   = '0;
         state_d = ST_IDLE;
      end else if (gap_q == '0) begin
         // Speed is sampled only here, so an interval in flight is never resized.
         if (!fifo_empty || (ts_in_vld && !fifo_full)) begin
            emit    = 1'b1;
            gap_d   = 6'(speed2gap(curr_speed) - 7'd1);
            state_d = ST_EMIT;
         end
      end else begin
         gap_d   = gap_q - 6'd1;
         state_d = (gap_d != '0) ? ST_WAIT : ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
         ts_out  <= '0;
         ovf_err <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         if (emit) ts_out <= head;
         if (ts_in_vld && fifo_full && !flush) ovf_err <= 1'b1;
      end
   end

   assign ts_out_vld = (state_q == ST_EMIT);

endmodule

// File: tb/tb_lane_tx_pacer.sv
// Self-checking bench for lane_tx_pacer: vector table, directed corner
// sequences and randomized traffic against a timestamp/queue reference model.
module tb_lane_tx_pacer;
   localparam int DEPTH = 4;
   localparam int TS_W  = 128;

   logic            clk = 1'b0;
   logic            rst;
   logic [TS_W-1:0] ts_in;
   logic            ts_in_vld;
   logic            fifo_full;
   logic [5:0]      curr_speed;
   logic            flush;
   logic [TS_W-1:0] ts_out;
   logic            ts_out_vld;
   logic            ovf_err;
   logic [2:0]      fifo_cnt;

   always #5 clk = ~clk;

   lane_tx_pacer #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .ts_in      (ts_in),
      .ts_in_vld  (ts_in_vld),
      .fifo_full  (fifo_full),
      .curr_speed (curr_speed),
      .flush      (flush),
      .ts_out     (ts_out),
      .ts_out_vld (ts_out_vld),
      .ovf_err    (ovf_err),
      .fifo_cnt   (fifo_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model: a queue of pending TS plus the earliest edge at which
   // the next emission is allowed.
   logic [TS_W-1:0] mq[$];
   int              ready_cyc = 0;
   logic            m_vld = 1'b0;
   logic [TS_W-1:0] m_ts  = '0;
   logic            m_ovf = 1'b0;

   int              p_cyc[$];
   logic [TS_W-1:0] p_dat[$];
   bit              full_seen;

   function automatic int interval(logic [5:0] s);
      for (int k = 0; k < 5; k++) if (s[k]) return 64 >> k;
      return 64;
   endfunction

   function automatic logic [TS_W-1:0] pat(logic [7:0] b);
      return {16{b}};
   endfunction

   task automatic check(string name, logic [TS_W-1:0] act, logic [TS_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      bit accept;
      m_vld = 1'b0;
      if (!rst) begin
         mq.delete();
         ready_cyc = cyc + 1;
         m_ts  = '0;
         m_ovf = 1'b0;
      end else if (flush) begin
         mq.delete();
         ready_cyc = cyc + 1;
      end else begin
         accept = ts_in_vld && (mq.size() < DEPTH);
         if (ts_in_vld && !accept) m_ovf = 1'b1;
         if (accept) mq.push_back(ts_in);
         if (cyc >= ready_cyc && mq.size() > 0) begin
            m_ts  = mq.pop_front();
            m_vld = 1'b1;
            ready_cyc = cyc + interval(curr_speed);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      check("m_vld",  TS_W'(ts_out_vld), TS_W'(m_vld));
      check("m_ts",   ts_out, m_ts);
      check("m_cnt",  TS_W'(fifo_cnt), TS_W'(mq.size()));
      check("m_full", TS_W'(fifo_full), TS_W'(mq.size() == DEPTH));
      check("m_ovf",  TS_W'(ovf_err), TS_W'(m_ovf));
      if (ts_out_vld) begin
         p_cyc.push_back(cyc);
         p_dat.push_back(ts_out);
      end
      if (fifo_full) full_seen = 1'b1;
   endtask

   task automatic reset_dut();
      rst = 1'b0; ts_in_vld = 1'b0; flush = 1'b0;
      tick();
      rst = 1'b1;
      p_cyc.delete(); p_dat.delete(); full_seen = 1'b0;
   endtask

   typedef struct {
      logic       vld;
      logic       fl;
      logic [7:0] b;
      logic       e_vld;
      logic [7:0] e_b;
      logic [2:0] e_cnt;
      logic       e_full;
      logic       e_ovf;
   } vec_t;

   vec_t vt[12];

   initial begin
      int w0;
      rst = 1'b0; ts_in = '0; ts_in_vld = 1'b0; flush = 1'b0; curr_speed = 6'b000001;

      // Gen5 table from reset: bypass emit, fill to full, overflow, flush, refill.
      vt[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 8'h11, 3'd0, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 8'h22, 1'b0, 8'h11, 3'd1, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 1'b0, 8'h33, 1'b0, 8'h11, 3'd2, 1'b0, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 8'h44, 1'b0, 8'h11, 3'd3, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 8'h55, 1'b1, 8'h22, 3'd3, 1'b0, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 8'h66, 1'b0, 8'h22, 3'd4, 1'b1, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 8'h77, 1'b0, 8'h22, 3'd4, 1'b1, 1'b1};
      vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 3'd4, 1'b1, 1'b1};
      vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 3'd3, 1'b0, 1'b1};
      vt[9]  = '{1'b1, 1'b1, 8'h88, 1'b0, 8'h33, 3'd0, 1'b0, 1'b1};
      vt[10] = '{1'b1, 1'b0, 8'h99, 1'b1, 8'h99, 3'd0, 1'b0, 1'b1};
      vt[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h99, 3'd0, 1'b0, 1'b1};

      tick(); tick();
      check("rst_vld",  TS_W'(ts_out_vld), '0);
      check("rst_ts",   ts_out, '0);
      check("rst_full", TS_W'(fifo_full), '0);
      check("rst_cnt",  TS_W'(fifo_cnt), '0);
      check("rst_ovf",  TS_W'(ovf_err), '0);

      curr_speed = 6'b010000;
      reset_dut();
      for (int i = 0; i < 12; i++) begin
         ts_in_vld = vt[i].vld; flush = vt[i].fl; ts_in = pat(vt[i].b);
         tick();
         check($sformatf("vec%0d_vld", i),  TS_W'(ts_out_vld), TS_W'(vt[i].e_vld));
         check($sformatf("vec%0d_ts", i),   ts_out, pat(vt[i].e_b));
         check($sformatf("vec%0d_cnt", i),  TS_W'(fifo_cnt), TS_W'(vt[i].e_cnt));
         check($sformatf("vec%0d_full", i), TS_W'(fifo_full), TS_W'(vt[i].e_full));
         check($sformatf("vec%0d_ovf", i),  TS_W'(ovf_err), TS_W'(vt[i].e_ovf));
      end
      ts_in_vld = 1'b0; flush = 1'b0;

      // Single TS at Gen1: next-cycle emission, no further pulses.
      curr_speed = 6'b000001;
      reset_dut();
      repeat (8) tick();
      ts_in = pat(8'hA5); ts_in_vld = 1'b1;
      tick();
      ts_in_vld = 1'b0;
      check("single_vld", TS_W'(ts_out_vld), TS_W'(1));
      check("single_ts", ts_out, pat(8'hA5));
      repeat (100) tick();
      check("single_pulses", TS_W'(p_cyc.size()), TS_W'(1));
      check("single_hold", ts_out, pat(8'hA5));

      // Gen3 back-to-back: 16-cycle spacing, order kept, never full.
      curr_speed = 6'b000100;
      reset_dut();
      w0 = cyc + 1;
      for (int i = 0; i < 60; i++) begin
         ts_in_vld = (i < 3); ts_in = pat(8'(8'h30 + i));
         tick();
      end
      ts_in_vld = 1'b0;
      check("b2b_count", TS_W'(p_cyc.size()), TS_W'(3));
      if (p_cyc.size() == 3) begin
         check("b2b_p0", TS_W'(p_cyc[0]), TS_W'(w0));
         check("b2b_p1", TS_W'(p_cyc[1] - w0), TS_W'(16));
         check("b2b_p2", TS_W'(p_cyc[2] - w0), TS_W'(32));
         check("b2b_d2", p_dat[2], pat(8'h32));
      end
      check("b2b_nofull", TS_W'(full_seen), '0);

      // Gen2 emission, switch to Gen5 five cycles later.
      curr_speed = 6'b000010;
      reset_dut();
      for (int i = 0; i < 80; i++) begin
         ts_in_vld = (i < 3); ts_in = pat(8'(8'h50 + i));
         if (i == 5) curr_speed = 6'b010000;
         tick();
      end
      ts_in_vld = 1'b0;
      check("spd_count", TS_W'(p_cyc.size()), TS_W'(3));
      if (p_cyc.size() == 3) begin
         check("spd_p1", TS_W'(p_cyc[1] - p_cyc[0]), TS_W'(32));
         check("spd_p2", TS_W'(p_cyc[2] - p_cyc[0]), TS_W'(36));
      end

      // Flush with 3 queued mid-interval, then a fresh write emits next cycle.
      curr_speed = 6'b000001;
      reset_dut();
      for (int i = 0; i < 150; i++) begin
         ts_in_vld = (i < 4); ts_in = pat(8'(8'h70 + i));
         flush = (i == 44);
         if (i == 44) check("flush_pre_cnt", TS_W'(fifo_cnt), TS_W'(3));
         tick();
         if (i == 44) check("flush_cnt", TS_W'(fifo_cnt), '0);
      end
      flush = 1'b0;
      check("flush_pulses", TS_W'(p_cyc.size()), TS_W'(1));
      ts_in = pat(8'hC3); ts_in_vld = 1'b1;
      tick();
      ts_in_vld = 1'b0;
      check("flush_fresh_vld", TS_W'(ts_out_vld), TS_W'(1));
      check("flush_fresh_ts", ts_out, pat(8'hC3));

      // Reset mid-operation with 2 entries queued.
      reset_dut();
      for (int i = 0; i < 10; i++) begin
         ts_in_vld = (i < 3); ts_in = pat(8'(8'h90 + i));
         tick();
      end
      ts_in_vld = 1'b0;
      check("mid_pre_cnt", TS_W'(fifo_cnt), TS_W'(2));
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("mid_vld",  TS_W'(ts_out_vld), '0);
      check("mid_ts",   ts_out, '0);
      check("mid_cnt",  TS_W'(fifo_cnt), '0);
      check("mid_full", TS_W'(fifo_full), '0);
      p_cyc.delete();
      repeat (100) tick();
      check("mid_no_pulse", TS_W'(p_cyc.size()), '0);

      // Randomized traffic against the reference model.
      reset_dut();
      for (int i = 0; i < 4000; i++) begin
         int dens;
         dens = (i / 500) % 4;
         rst       = ($urandom_range(0, 599) != 0);
         flush     = ($urandom_range(0, 149) == 0);
         ts_in_vld = ($urandom_range(0, 7) < dens * 2 + 1);
         ts_in     = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 59) == 0) begin
            case ($urandom_range(0, 7))
               0: curr_speed = 6'b000001;
               1: curr_speed = 6'b000010;
               2: curr_speed = 6'b000100;
               3: curr_speed = 6'b001000;
               4: curr_speed = 6'b010000;
               5: curr_speed = 6'b000000;
               6: curr_speed = 6'b100000;
               default: curr_speed = 6'($urandom);
            endcase
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
